serial_comp_nbit: RTL and testbench

SERIAL_COMP_NBIT -- requirements
Module: serial_comp_nbit

---
 rtl/serial_comp_pkg.sv | 16 +
 rtl/cmp_bit_cell.sv | 14 +
 rtl/serial_comp_nbit.sv | 113 +++++++++++
 tb/tb_serial_comp_nbit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_comp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM state encoding
// and the bit-step counter width helper.
package serial_comp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Counter must reach WIDTH itself without wrapping, hence the extra bit.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// Single-bit unsigned comparison cell: flags a<b, a==b and a>b for one bit pair.
module cmp_bit_cell (
    input  logic a,
    input  logic b,
    output logic l,
    output logic e,
    output logic g
);

    assign l = ~a & b;
    assign e = ~(a ^ b);
    assign g = a & ~b;

endmodule

// File: rtl/serial_comp_nbit.sv
// Bit-serial MSB-first magnitude comparator with fixed WIDTH+1 cycle latency.
// Define SERIAL_COMP_SIGNED_EN to treat operands as two's complement.
module serial_comp_nbit
    import serial_comp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             l,
    output logic             e,
    output logic             g
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

`ifdef SERIAL_COMP_SIGNED_EN
    localparam bit SIGNED_OPS = 1'b1;
`else
    localparam bit SIGNED_OPS = 1'b0;
`endif

    state_t           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;
    logic             decided;
    logic             dir_lt;

    logic             bit_l;
    logic             bit_e;
    logic             bit_g;
    logic             step_lt;

    cmp_bit_cell u_cell (
        .a (sh_a[WIDTH-1]),
        .b (sh_b[WIDTH-1]),
        .l (bit_l),
        .e (bit_e),
        .g (bit_g)
    );

    // A set sign bit means the smaller value, so the MSB step flips direction.
    always_comb begin
        step_lt = bit_l;
        if (SIGNED_OPS && cnt == '0)
            step_lt = bit_g;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sh_a    <= '0;
            sh_b    <= '0;
            cnt     <= '0;
            decided <= 1'b0;
            dir_lt  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            l       <= 1'b0;
            e       <= 1'b0;
            g       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a    <= a;
                        sh_b    <= b;
                        cnt     <= '0;
                        decided <= 1'b0;
                        dir_lt  <= 1'b0;
                        l       <= 1'b0;
                        e       <= 1'b0;
                        g       <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Only the first differing pair counts; all WIDTH steps still run.
                    if (!decided && !bit_e) begin
                        decided <= 1'b1;
                        dir_lt  <= step_lt;
                    end
                    sh_a <= {sh_a[WIDTH-2:0], 1'b0};
                    sh_b <= {sh_b[WIDTH-2:0], 1'b0};
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST_STEP)
                        state <= DONE;
                end
                DONE: begin
                    l     <= decided & dir_lt;
                    g     <= decided & ~dir_lt;
                    e     <= ~decided;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_comp_nbit.sv
// Scoreboard bench for serial_comp_nbit: WIDTH=8 and WIDTH=2 instances against
// an arithmetic reference; results and done latency are checked by monitors.
module tb_serial_comp_nbit;

    localparam int W8 = 8;
    localparam int W2 = 2;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8, b8;
    logic       busy8, done8, l8, e8, g8;

    logic       start2;
    logic [1:0] a2, b2;
    logic       busy2, done2, l2, e2, g2;

    int cyc    = 0;
    int passed = 0;
    int total  = 0;

    // Entry: {expected l,e,g ; cycle count at which done must be seen}
    logic [34:0] exp8_q[$];
    logic [34:0] exp2_q[$];
    logic [34:0] ent8, ent2;
    logic [2:0]  last8 = 3'b000;
    logic [2:0]  last2 = 3'b000;

    serial_comp_nbit #(.WIDTH(W8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .l     (l8),
        .e     (e8),
        .g     (g8)
    );

    serial_comp_nbit #(.WIDTH(W2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start2),
        .a     (a2),
        .b     (b2),
        .busy  (busy2),
        .done  (done2),
        .l     (l2),
        .e     (e2),
        .g     (g2)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    // Reference: plain arithmetic comparison, returns {lt, eq, gt}.
    function automatic logic [2:0] ref_cmp(input logic [63:0] x, input logic [63:0] y, input int w);
        longint sx, sy;
`ifdef SERIAL_COMP_SIGNED_EN
        sx = longint'(x << (64 - w)) >>> (64 - w);
        sy = longint'(y << (64 - w)) >>> (64 - w);
`else
        sx = longint'(x);
        sy = longint'(y);
`endif
        if (sx < sy)       return 3'b100;
        else if (sx == sy) return 3'b010;
        else               return 3'b001;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // driver tasks: start is held for one accepting edge, then operands are scrambled
    task automatic issue8(input logic [7:0] x, input logic [7:0] y, input bit expect_it);
        @(negedge clk);
        start8 = 1'b1;
        a8 = x;
        b8 = y;
        if (expect_it) exp8_q.push_back({ref_cmp(64'(x), 64'(y), W8), 32'(cyc + W8 + 2)});
        @(negedge clk);
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
    endtask

    task automatic issue2(input logic [1:0] x, input logic [1:0] y);
        @(negedge clk);
        start2 = 1'b1;
        a2 = x;
        b2 = y;
        exp2_q.push_back({ref_cmp(64'(x), 64'(y), W2), 32'(cyc + W2 + 2)});
        @(negedge clk);
        start2 = 1'b0;
        a2 = 2'($urandom);
        b2 = 2'($urandom);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst_n) begin
            last8 = 3'b000;
            last2 = 3'b000;
        end else begin
            if (done8) begin
                if (exp8_q.size() == 0) begin
                    check("w8 unexpected done", 64'(done8), 64'd0);
                end else begin
                    ent8 = exp8_q.pop_front();
                    check("w8 result lge", 64'({l8, e8, g8}), 64'(ent8[34:32]));
                    check("w8 done latency", 64'(cyc), 64'(ent8[31:0]));
                    last8 = ent8[34:32];
                end
            end else if (!busy8) begin
                check("w8 idle hold lge", 64'({l8, e8, g8}), 64'(last8));
            end

            if (done2) begin
                if (exp2_q.size() == 0) begin
                    check("w2 unexpected done", 64'(done2), 64'd0);
                end else begin
                    ent2 = exp2_q.pop_front();
                    check("w2 result lge", 64'({l2, e2, g2}), 64'(ent2[34:32]));
                    check("w2 done latency", 64'(cyc), 64'(ent2[31:0]));
                    last2 = ent2[34:32];
                end
            end else if (!busy2) begin
                check("w2 idle hold lge", 64'({l2, e2, g2}), 64'(last2));
            end
        end
    end

    initial begin
        logic [7:0] ra, rb;
        rst_n  = 1'b0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        start2 = 1'b0;
        a2     = '0;
        b2     = '0;
        #1;
        check("reset busy8", 64'(busy8), 64'd0);
        check("reset done8", 64'(done8), 64'd0);
        check("reset lge8", 64'({l8, e8, g8}), 64'd0);
        check("reset busy2", 64'(busy2), 64'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        fork
            begin
                issue8(8'h5A, 8'h5A, 1'b1);
                repeat (W8) @(negedge clk);
                issue8(8'h80, 8'h7F, 1'b1);
                repeat (W8 + 1) @(negedge clk);
                issue8(8'h01, 8'h02, 1'b1);
                repeat (W8) @(negedge clk);
                issue8(8'hFF, 8'hFE, 1'b1);
                repeat (W8 + 2) @(negedge clk);

                // second start three cycles into the operation must be ignored
                issue8(8'h10, 8'h20, 1'b1);
                repeat (2) @(negedge clk);
                start8 = 1'b1;
                a8 = 8'h30;
                b8 = 8'h00;
                check("w8 busy mid-shift", 64'(busy8), 64'd1);
                @(negedge clk);
                start8 = 1'b0;
                repeat (W8 - 3) @(negedge clk);

                for (int i = 0; i < 30; i++) begin
                    ra = 8'($urandom);
                    case ($urandom_range(0, 3))
                        0:       rb = ra;
                        1:       rb = ra ^ (8'd1 << $urandom_range(0, 7));
                        default: rb = 8'($urandom);
                    endcase
                    issue8(ra, rb, 1'b1);
                    repeat (W8 + $urandom_range(0, 2)) @(negedge clk);
                end
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    for (int j = 0; j < 4; j++) begin
                        issue2(2'(i), 2'(j));
                        repeat (W2 + $urandom_range(0, 1)) @(negedge clk);
                    end
                end
                for (int i = 0; i < 10; i++) begin
                    issue2(2'($urandom), 2'($urandom));
                    repeat (W2 + $urandom_range(0, 2)) @(negedge clk);
                end
            end
        join
        repeat (12) @(negedge clk);

        // reset four cycles into SHIFT aborts without a done pulse
        issue8(8'($urandom), 8'($urandom), 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort busy8", 64'(busy8), 64'd0);
        check("abort done8", 64'(done8), 64'd0);
        check("abort l8", 64'(l8), 64'd0);
        check("abort e8", 64'(e8), 64'd0);
        check("abort g8", 64'(g8), 64'd0);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (W8 + 4) @(negedge clk);
        issue8(8'h03, 8'h03, 1'b1);

        for (int k = 0; k < 100 && (exp8_q.size() != 0 || exp2_q.size() != 0); k++)
            @(negedge clk);
        repeat (4) @(negedge clk);
        check("w8 pending results", 64'(exp8_q.size()), 64'd0);
        check("w2 pending results", 64'(exp2_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
